// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between pipeline
// writeback (primary) and a long-latency unit (secondary, queued in order).
// Optional build macro: RFARB_BYPASS_EN lets a secondary result go straight to
// the write port when the queue is empty and writeback is idle.
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_data,
  output logic                     wb_stall,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_reg,
  input  logic [31:0]              lu_data,
  output logic                     rf_reg_write,
  output logic [4:0]               rf_write_reg,
  output logic [31:0]              rf_write_data,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] SLIM     = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_WB,
    SEL_HEAD,
    SEL_LU
  } sel_e;

  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          alive;
  logic          wb_req;
  logic          q_req;
  logic          full;
  logic          push;
  logic          pop;
  sel_e          sel;

  assign q_count  = count;
  assign full     = (count == FULL_CNT);
  // alive keeps lu_ready low while reset is held and for the release cycle
  assign lu_ready = alive && !full;
  // rst gating keeps the write port quiet while reset is asserted
  assign wb_req   = wb_valid && (wb_reg != '0) && !rst;
  assign q_req    = (count != '0);
  assign pop      = (sel == SEL_HEAD);
  assign wb_stall = wb_req && pop;
  assign push     = lu_valid && lu_ready && (lu_reg != '0) && (sel != SEL_LU);

  // Write-port grant: head wins when WB is idle or the queue has starved
  always_comb begin
    sel = SEL_NONE;
    if (q_req && (!wb_req || starve_cnt == SLIM)) begin
      sel = SEL_HEAD;
    end else if (wb_req) begin
      sel = SEL_WB;
    end
`ifdef RFARB_BYPASS_EN
    else if (!q_req && lu_valid && lu_ready && (lu_reg != '0)) begin
      sel = SEL_LU;
    end
`endif
  end

  // Register-file write mux; zero address/data when nothing is granted
  always_comb begin
    rf_reg_write  = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    case (sel)
      SEL_WB: begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = wb_reg;
        rf_write_data = wb_data;
      end
      SEL_HEAD: begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = q_reg[rd_ptr];
        rf_write_data = q_data[rd_ptr];
      end
      SEL_LU: begin
        rf_reg_write  = 1'b1;
        rf_write_reg  = lu_reg;
        rf_write_data = lu_data;
      end
      default: ;
    endcase
  end

  // Busy mask: OR of one-hot destinations over the occupied window
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(PW'(i - 32'(rd_ptr))) < count) begin
        busy_mask[q_reg[i]] = 1'b1;
      end
    end
  end

  // Queue storage; contents are qualified by pointers/count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= lu_reg;
      q_data[wr_ptr] <= lu_data;
    end
  end

  // Pointers, occupancy, starvation counter and post-reset ready enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      alive      <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (!q_req || pop) begin
        starve_cnt <= '0;
      end else if (wb_req && starve_cnt != SLIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port between the pipeline writeback stage (primary) and a long-latency unit such as mul/div (secondary). Secondary writes are buffered in a small in-order queue. The queue drains into idle write-port cycles, and the pipeline is stalled when the queue is starved. The block also exports a busy mask of registers with queued writes, for the hazard unit.

Parameters:
DEPTH, 4, secondary queue entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive cycles a non-empty queue may lose arbitration before a forced grant (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; one clock; reset is asynchronous and active-high
wb_valid  in  1  pipeline writeback request
wb_reg  in  5  writeback destination register
wb_data  in  32  writeback data
wb_stall  out  1  writeback not granted this cycle; pipeline holds WB inputs stable
lu_valid  in  1  long-latency unit result valid
lu_ready  out  1  queue can accept; transfer when lu_valid && lu_ready at posedge
lu_reg  in  5  long-latency destination register
lu_data  in  32  long-latency result
rf_reg_write  out  1  register file write enable
rf_write_reg  out  5  register file write address
rf_write_data  out  32  register file write data
busy_mask  out  32  bit i = 1 while any queued entry targets register i
q_count  out  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Queue storage:
  - Circular FIFO with rd/wr pointers and a count.
  - Full when count==DEPTH. Empty when count==0. Pointers wrap modulo DEPTH.
- Effective requests:
  - wb_req = wb_valid && wb_reg!=0. Writeback to r0 is dropped: no rf write, no stall.
  - q_req = !empty.
- Per-cycle grant (combinational from current state):
  - Only wb_req: grant WB. rf_* = wb_*.
  - Only q_req: grant head. rf_* = head entry. Pop at posedge.
  - Both, starve_cnt < STARVE_LIMIT: grant WB. starve_cnt increments at posedge.
  - Both, starve_cnt == STARVE_LIMIT: grant head, wb_stall=1, pop at posedge.
  - Neither: rf_reg_write=0. rf_write_reg and rf_write_data are 0.
- starve_cnt:
  - Clears to 0 at posedge whenever the head is granted or the queue is empty.
  - Saturates at STARVE_LIMIT.
- wb_stall = wb_req && head granted. It is never asserted when the queue is empty.
- Enqueue and lu_ready:
  - lu_ready = !full, driven from registered count.
  - A full queue does not accept even if a pop occurs the same cycle.
  - Handshake with lu_reg==0 is accepted and discarded; nothing is enqueued.
- Simultaneous enqueue and pop: both take effect; count unchanged.
- Latency:
  - WB path is 0 cycles (combinational to rf_*).
  - Secondary path is at least 1 cycle from handshake to rf write.
- Ordering and busy_mask:
  - Queue drains strictly in order.
  - busy_mask is the OR of one-hot(reg) over valid entries. A bit clears the cycle after the last matching entry pops.
  - The hazard unit must use busy_mask to block WAW/RAW on queued registers. The arbiter does no reordering checks.
- Reset, asserted at any time:
  - Queue flushed; pointers, count and starve_cnt go to 0.
  - busy_mask=0, rf_reg_write=0, wb_stall=0, lu_ready=0.
  - In-flight queued writes are lost.
  - lu_ready rises the first cycle after rst deasserts.

Optional Feature:
RFARB_BYPASS_EN
- Defined: when the queue is empty, wb_req=0 and lu_valid=1 with lu_reg!=0, the secondary write goes straight to rf_* in the same cycle. It is not enqueued, and busy_mask is unaffected. lu_ready is still !full.
- Undefined: every secondary write is enqueued first, with a minimum of 1 cycle latency.

Test Plan:
- Reset then idle:
  - Stimulus: rst high for 3 cycles, then low.
  - Response: rf_reg_write=0, busy_mask=0, q_count=0. lu_ready=0 during reset and 1 the cycle after release.
- WB only:
  - Stimulus: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF.
  - Response: same cycle rf_reg_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF, wb_stall=0.
  - Stimulus: wb_reg=0.
  - Response: rf_reg_write=0.
- Queue drain:
  - Stimulus: enqueue lu r7=0x11, then r7=0x22, with wb idle.
  - Response: busy_mask[7]=1. rf writes r7=0x11 then r7=0x22 on consecutive cycles. busy_mask[7]=0 after the second pop. Without RFARB_BYPASS_EN, the first write is 1 cycle after the handshake.
- Starvation:
  - Stimulus: one queued entry r3=0x33, wb_valid held with r9 continuously.
  - Response: WB granted for 8 cycles. Cycle 9: wb_stall=1, rf writes r3=0x33. Cycle 10: WB r9 granted, wb_stall=0.
- Full/wrap:
  - Stimulus: wb busy; enqueue 4 entries.
  - Response: lu_ready=0 with q_count=4. A 5th lu_valid is not accepted. Pop/push 10 more entries: order is preserved across pointer wrap.
- Reset mid-operation:
  - Stimulus: 3 entries queued, assert rst for 1 cycle.
  - Response: q_count=0, busy_mask=0, no rf write of the flushed entries afterwards.
